// File: rtl/stopwatch_pkg.sv
// Shared types, widths and the seven-segment lookup for the stopwatch display path.
package stopwatch_pkg;

  localparam int unsigned MIN_W = 8;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned ST_W  = 2;
  localparam int unsigned BIN_W = 8;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned DIG_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_RSVD  = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_LOAD  = 2'd2
  } conv_state_e;

  // Active-low common-anode pattern, bit0 = segment a .. bit6 = segment g.
  function automatic logic [6:0] seg_encode(input logic [DIG_W-1:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// Time/status bus from stopwatch_top (master) to stopwatch_display (slave).
//   minutes : binary minutes
//   seconds : binary seconds, 0..59
//   status  : 00 idle, 01 running, 10 paused, 11 reserved
interface stopwatch_display_if;
  import stopwatch_pkg::*;

  logic [MIN_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic [ST_W-1:0]  status;

  modport master (output minutes, seconds, status);
  modport slave  (input  minutes, seconds, status);
endinterface

// File: rtl/stopwatch_display_bin2bcd_seq.sv
// Sequential double-dabble converter: LANES independent 8-bit operands
// converted in parallel, one iteration per cycle, 8 iterations.
//   start  : load operands (ignored while busy)
//   bin    : packed operands, lane 0 in the low byte
//   busy   : iteration in progress
//   done_c : combinational, high in the cycle of the final iteration
//   bcd    : packed 12-bit BCD results, valid once busy falls
module bin2bcd_seq
  import stopwatch_pkg::*;
#(
  parameter int unsigned LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LANES*BIN_W-1:0] bin,
  output logic                   busy,
  output logic                   done_c,
  output logic [LANES*BCD_W-1:0] bcd
);

  localparam int unsigned ITERS = BIN_W;
  localparam int unsigned CNT_W = $clog2(ITERS);

  logic [LANES*BIN_W-1:0] sh_q;
  logic [LANES*BIN_W-1:0] sh_d;
  logic [LANES*BCD_W-1:0] bcd_d;
  logic [CNT_W-1:0]       cnt_q;

  // Add 3 to every BCD nibble that is 5 or more before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int n = 0; n < int'(BCD_W / 4); n++) begin
      if (r[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = r[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // One iteration per lane: adjust, then shift the binary MSB into the BCD field.
  always_comb begin
    sh_d  = sh_q;
    bcd_d = bcd;
    for (int l = 0; l < int'(LANES); l++) begin
      {bcd_d[l*BCD_W +: BCD_W], sh_d[l*BIN_W +: BIN_W]} =
        {dabble_adjust(bcd[l*BCD_W +: BCD_W]), sh_q[l*BIN_W +: BIN_W]} << 1;
    end
  end

  assign done_c = busy && (cnt_q == CNT_W'(ITERS - 1));

  // Iteration sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt_q <= '0;
      sh_q  <= '0;
      bcd   <= '0;
    end else if (start && !busy) begin
      busy  <= 1'b1;
      cnt_q <= '0;
      sh_q  <= bin;
      bcd   <= '0;
    end else if (busy) begin
      sh_q  <= sh_d;
      bcd   <= bcd_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_c) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch 4-digit multiplexed common-anode 7-segment driver.
//   clk, rst_n : clock, async active-low reset
//   sw         : time/status bus (slave side)
//   seg_n      : active-low segments, bit0 = a .. bit6 = g
//   an_n       : active-low digit enables, bit3 = minutes tens .. bit0 = seconds units
//   dp_n       : active-low colon, shown on the minutes-units digit
//   busy       : BCD conversion in progress
module stopwatch_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic               clk,
  input  logic               rst_n,
  stopwatch_display_if.slave sw,
  output logic [6:0]         seg_n,
  output logic [3:0]         an_n,
  output logic               dp_n,
  output logic               busy
);

  localparam int unsigned LANES   = 2;
  localparam int unsigned SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  conv_state_e state_q, state_d;
  logic        start_c, load_c, changed_c;

  logic [MIN_W-1:0]       cap_min_q, min_sat_c;
  logic [SEC_W-1:0]       cap_sec_q;
  logic [LANES*BIN_W-1:0] eng_bin_c;
  logic [LANES*BCD_W-1:0] eng_bcd;
  logic                   eng_busy, eng_done_c;
  logic                   unused_hundreds;

  logic [4*DIG_W-1:0] digits_q;
  logic [SCAN_W-1:0]  scan_cnt_q;
  logic [1:0]         scan_idx_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               blink_phase_q;
  logic [ST_W-1:0]    status_q;
  logic               pause_entry_c, colon_n_c;

  assign changed_c = {sw.minutes, sw.seconds} != {cap_min_q, cap_sec_q};
  assign min_sat_c = (sw.minutes > MIN_W'(99)) ? MIN_W'(99) : sw.minutes;
  // Lane 0 = seconds, lane 1 = minutes.
  assign eng_bin_c = {BIN_W'(min_sat_c), BIN_W'(sw.seconds)};

  bin2bcd_seq #(.LANES(LANES)) u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_c),
    .bin    (eng_bin_c),
    .busy   (eng_busy),
    .done_c (eng_done_c),
    .bcd    (eng_bcd)
  );

  // Both values are clamped to 99, so the hundreds nibbles are always zero.
  assign unused_hundreds = ^{eng_bcd[BCD_W+8 +: 4], eng_bcd[8 +: 4]};

  // Conversion FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CONV_IDLE;
    else        state_q <= state_d;
  end

  // Conversion FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CONV_IDLE:  if (changed_c && !eng_busy) state_d = CONV_SHIFT;
      CONV_SHIFT: if (eng_done_c)             state_d = CONV_LOAD;
      CONV_LOAD:                              state_d = CONV_IDLE;
      default:                                state_d = CONV_IDLE;
    endcase
  end

  // Conversion FSM: control strobes.
  always_comb begin
    start_c = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      CONV_IDLE: start_c = changed_c && !eng_busy;
      CONV_LOAD: load_c  = 1'b1;
      default: ;
    endcase
  end

  // Capture, busy flag and display digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_min_q <= '0;
      cap_sec_q <= '0;
      busy      <= 1'b0;
      digits_q  <= '0;
    end else begin
      busy <= (state_d != CONV_IDLE);
      if (start_c) begin
        cap_min_q <= sw.minutes;
        cap_sec_q <= sw.seconds;
      end
      if (load_c) begin
        digits_q <= {eng_bcd[BCD_W+4 +: 4], eng_bcd[BCD_W +: 4],
                     eng_bcd[4 +: 4],       eng_bcd[0 +: 4]};
      end
    end
  end

  // Blink restarts lit whenever status enters paused.
  assign pause_entry_c = (sw.status == ST_PAUSE) && (status_q != ST_PAUSE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q      <= ST_IDLE;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      status_q <= sw.status;
      if (pause_entry_c) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b0;
      end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  always_comb begin
    colon_n_c = 1'b1;
    case (status_q)
      ST_RUN:   colon_n_c = 1'b0;
      ST_PAUSE: colon_n_c = blink_phase_q;
      default:  colon_n_c = 1'b1;
    endcase
  end

  // Digit scan; an_n, seg_n and dp_n all derive from the same index on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q <= '0;
      scan_idx_q <= 2'd0;
      an_n       <= 4'hF;
      seg_n      <= SEG_BLANK;
      dp_n       <= 1'b1;
    end else begin
      if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt_q <= '0;
        scan_idx_q <= scan_idx_q + 2'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
      end
      an_n  <= ~(4'b0001 << scan_idx_q);
      seg_n <= seg_encode(digits_q[{scan_idx_q, 2'b00} +: DIG_W]);
      dp_n  <= (scan_idx_q == 2'd2) ? colon_n_c : 1'b1;
    end
  end

endmodule
